// File: rtl/fifo_word_serializer.sv
// rtl/fifo_word_serializer.sv - pops IN_WIDTH words from a FIFO and emits them as RATIO narrow beats
module fifo_word_serializer #(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int OUT_WIDTH = IN_WIDTH / RATIO,
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 last_o,
  output logic                 busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  state_e              state, state_next;
  logic [IN_WIDTH-1:0] hold, hold_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [CNT_W-1:0]    slice_idx;
  logic                last_beat;

  assign last_beat = (cnt == CNT_MAX);
  assign busy_o    = (state == SHIFT);

  // MSB-first order walks the slices downward from the top of the word.
  assign slice_idx = LSB_FIRST ? cnt : (CNT_MAX - cnt);

  generate
    if (RATIO == 1) begin : g_single
      assign data_o = hold;
    end else begin : g_sel
      logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
      assign slices = hold;
      assign data_o = slices[slice_idx];
    end
  endgenerate

  // State, holding register and beat counter; reset discards any held word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      hold  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and handshake logic; flush wins over every other event.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    cnt_next   = cnt;
    fifo_pop_o = 1'b0;
    valid_o    = 1'b0;
    last_o     = 1'b0;
    case (state)
      IDLE: begin
        // rst_ni gates the pop so the FIFO is never drained while held in reset.
        if (rst_ni && !flush_i && !fifo_empty_i) begin
          fifo_pop_o = 1'b1;
          hold_next  = fifo_data_i;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        valid_o = 1'b1;
        last_o  = last_beat;
        if (flush_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (ready_i) begin
          if (!last_beat) begin
            cnt_next = cnt + 1'b1;
          end else if (!fifo_empty_i) begin
            // Reload on the final beat so back-to-back words have no bubble.
            fifo_pop_o = 1'b1;
            hold_next  = fifo_data_i;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Simulation-only sanity checks on configuration and pop legality.
  always @(posedge clk_i) begin
    assert (IN_WIDTH % RATIO == 0) else $error("IN_WIDTH is not a multiple of RATIO");
    assert (RATIO >= 1) else $error("RATIO must be at least 1");
    assert (!(fifo_pop_o && fifo_empty_i)) else $error("pop while FIFO empty");
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb/tb_fifo_word_serializer.sv - self-checking bench for fifo_word_serializer
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        ready;

  logic        pop, valid, last, busy;
  logic [7:0]  data;
  logic        pop_m, valid_m, last_m, busy_m;
  logic [7:0]  data_m;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];

  bit          m_held;
  int          m_beat;
  logic [31:0] m_word;

  always #5 clk = ~clk;

  fifo_word_serializer u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_pop_o(pop), .valid_o(valid), .ready_i(ready),
    .data_o(data), .last_o(last), .busy_o(busy)
  );

  fifo_word_serializer #(.LSB_FIRST(1'b0)) u_dut_msb (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_pop_o(pop_m), .valid_o(valid_m), .ready_i(ready),
    .data_o(data_m), .last_o(last_m), .busy_o(busy_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() == 0) ? 32'h0 : q[0];
  endtask

  task automatic model_reset();
    m_held = 0;
    m_beat = 0;
    m_word = 32'h0;
  endtask

  // Set inputs, let them settle, compare every output against the model.
  task automatic apply(input logic r, input logic f);
    logic exp_pop;
    logic [7:0] exp_l, exp_m;
    ready = r;
    flush = f;
    #1;
    exp_pop = rst_n && !f && !fifo_empty && (!m_held || (r && m_beat == 3));
    exp_l = 8'((m_word >> (8 * m_beat)) & 32'hFF);
    exp_m = 8'((m_word >> (8 * (3 - m_beat))) & 32'hFF);
    chk("pop", pop, exp_pop);
    chk("pop_msb", pop_m, exp_pop);
    chk("valid", valid, m_held);
    chk("valid_msb", valid_m, m_held);
    chk("busy", busy, m_held);
    chk("last", last, m_held && m_beat == 3);
    chk("last_msb", last_m, m_held && m_beat == 3);
    if (m_held) begin
      chk("data", data, exp_l);
      chk("data_msb", data_m, exp_m);
    end
  endtask

  // Advance the model by one cycle's rules, then clock the DUT and the FIFO.
  task automatic advance();
    logic p;
    if (flush) begin
      m_held = 0;
      m_beat = 0;
    end else if (!m_held) begin
      if (!fifo_empty) begin
        m_held = 1;
        m_word = fifo_data;
        m_beat = 0;
      end
    end else if (ready) begin
      if (m_beat == 3) begin
        if (!fifo_empty) begin
          m_word = fifo_data;
          m_beat = 0;
        end else begin
          m_held = 0;
          m_beat = 0;
        end
      end else begin
        m_beat++;
      end
    end
    p = pop;
    @(posedge clk);
    #1;
    if (p) void'(q.pop_front());
    drive_fifo();
  endtask

  task automatic step(input logic r, input logic f);
    apply(r, f);
    advance();
  endtask

  initial begin
    logic [7:0] seq_l[4];
    logic [7:0] seq_m[4];
    seq_l = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    seq_m = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};

    rst_n = 1'b0;
    ready = 1'b0;
    flush = 1'b0;
    q.push_back(32'h12345678);
    drive_fifo();
    model_reset();
    #1;
    chk("reset_valid", valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_last", last, 1'b0);
    chk("reset_data", data, 8'h00);
    chk("reset_pop", pop, 1'b0);
    q.delete();
    drive_fifo();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0);

    // Single word, both slice orders.
    q.push_back(32'hDDCCBBAA);
    drive_fifo();
    apply(1, 0);
    chk("w1_pop_c0", pop, 1'b1);
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(1, 0);
      chk("w1_beat", data, seq_l[i]);
      chk("w1_beat_msb", data_m, seq_m[i]);
      chk("w1_last", last, i == 3);
      advance();
    end
    apply(1, 0);
    chk("w1_idle_c5", busy, 1'b0);
    advance();

    // Two queued words stream back to back.
    q.push_back(32'h44332211);
    q.push_back(32'h88776655);
    drive_fifo();
    step(1, 0);
    for (int i = 1; i <= 8; i++) begin
      apply(1, 0);
      chk("b2b_valid", valid, 1'b1);
      chk("b2b_data", data, 8'(8'h11 * i));
      chk("b2b_pop", pop, i == 4);
      advance();
    end
    apply(1, 0);
    chk("b2b_idle", valid, 1'b0);
    advance();

    // Downstream stall holds the beat stable.
    q.push_back(32'hDDCCBBAA);
    drive_fifo();
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0);
      chk("stall_data", data, 8'hBB);
      chk("stall_valid", valid, 1'b1);
      chk("stall_pop", pop, 1'b0);
      advance();
    end
    for (int i = 0; i < 4; i++) step(1, 0);

    // Flush mid-word with the FIFO non-empty.
    q.push_back(32'hDDCCBBAA);
    q.push_back(32'h44332211);
    drive_fifo();
    step(1, 0);
    step(1, 0);
    apply(1, 1);
    chk("flush_beat", data, 8'hBB);
    chk("flush_nopop", pop, 1'b0);
    advance();
    apply(1, 0);
    chk("flush_valid_drop", valid, 1'b0);
    chk("flush_repop", pop, 1'b1);
    advance();
    apply(1, 0);
    chk("flush_first_beat", data, 8'h11);
    chk("flush_first_last", last, 1'b0);
    advance();
    for (int i = 0; i < 4; i++) step(1, 0);

    // Asynchronous reset mid-word.
    q.push_back(32'hDDCCBBAA);
    drive_fifo();
    step(1, 0);
    step(1, 0);
    step(1, 0);
    apply(1, 0);
    chk("rst_pre_beat", data, 8'hCC);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_data", data, 8'h00);
    q.push_back(32'hCAFEF00D);
    drive_fifo();
    #1;
    chk("rst_pop_nonempty", pop, 1'b0);
    q.delete();
    drive_fifo();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1, 0);
      chk("post_rst_valid", valid, 1'b0);
      chk("post_rst_pop", pop, 1'b0);
      advance();
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (q.size() < 4 && $urandom_range(1, 0) == 1) begin
        q.push_back($urandom);
        drive_fifo();
      end
      step($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_word_serializer.md
FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

Interface
REQ-001 Parameter IN_WIDTH, default 32: width of the word popped from the upstream FIFO.
REQ-002 Parameter RATIO, default 4: beats emitted per word; IN_WIDTH SHALL be an integer multiple of RATIO; RATIO >= 1.
REQ-003 Parameter LSB_FIRST, default 1'b1: 1 emits slice [OUT_WIDTH-1:0] first; 0 emits the MSB slice first.
REQ-004 Derived parameter OUT_WIDTH = IN_WIDTH/RATIO, not to be overridden; CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1.
REQ-005 clk_i  input  1  clock; all state on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 flush_i  input  1  synchronous abort of the word in progress.
REQ-008 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-009 fifo_data_i  input  IN_WIDTH  upstream FIFO head word.
REQ-010 fifo_pop_o  output  1  pop strobe to upstream FIFO.
REQ-011 valid_o  output  1  output beat valid.
REQ-012 ready_i  input  1  downstream accepts beat.
REQ-013 data_o  output  OUT_WIDTH  current beat.
REQ-014 last_o  output  1  current beat is the final beat of its word.
REQ-015 busy_o  output  1  a word is held (state SHIFT).

Function
REQ-016 The block SHALL have two states: IDLE (no word held) and SHIFT (word held in an IN_WIDTH holding register, beat counter cnt of CNT_W bits).
REQ-017 IDLE: fifo_pop_o = ~fifo_empty_i & ~flush_i (combinational); on pop, the holding register SHALL capture fifo_data_i, cnt <= 0, state <= SHIFT.
REQ-018 SHIFT: valid_o = 1; data_o = slice cnt of the holding register (slice RATIO-1-cnt when LSB_FIRST = 0); last_o = (cnt == RATIO-1).
REQ-019 Beat transfer SHALL occur when valid_o & ready_i; without transfer, valid_o, data_o, last_o SHALL stay stable.
REQ-020 Transfer with last_o = 0: cnt <= cnt + 1, no pop.
REQ-021 Transfer with last_o = 1 and fifo_empty_i = 0: fifo_pop_o = 1 in the same cycle, holding register reloads, cnt <= 0, state stays SHIFT (no bubble between words).
REQ-022 Transfer with last_o = 1 and fifo_empty_i = 1: state <= IDLE, no pop.
REQ-023 fifo_pop_o SHALL never assert while fifo_empty_i = 1, and SHALL never assert in SHIFT except per REQ-021.
REQ-024 Latency: first beat valid one cycle after the pop cycle; steady-state throughput one beat per cycle with ready_i held high.
REQ-025 RATIO = 1: every beat SHALL have last_o = 1; cnt stays 0; data_o = holding register.
REQ-026 flush_i = 1 SHALL override all other events: state <= IDLE, cnt <= 0, fifo_pop_o = 0 that cycle; the held word is discarded; valid_o may drop without a handshake only in this case.
REQ-027 ready_i SHALL be ignored in IDLE; valid_o = 0, last_o = 0 in IDLE.
REQ-028 busy_o = 1 exactly when state = SHIFT.

Reset
REQ-029 While rst_ni = 0: state = IDLE, cnt = 0, holding register = 0; hence valid_o = 0, last_o = 0, busy_o = 0, data_o = 0.
REQ-030 fifo_pop_o SHALL be 0 during reset regardless of fifo_empty_i.
REQ-031 Reset asserted mid-word SHALL discard the word; after release, operation restarts from IDLE with the next available FIFO word.
REQ-032 Simulation-only assertions SHALL check IN_WIDTH % RATIO == 0, RATIO >= 1, and ~(fifo_pop_o & fifo_empty_i).

Verification
REQ-033 Defaults, FIFO holds 0xDDCCBBAA, ready_i = 1 -> pop in cycle 0; beats 0xAA,0xBB,0xCC,0xDD in cycles 1-4; last_o only with 0xDD; back to IDLE in cycle 5.
REQ-034 LSB_FIRST = 0, same word -> beats 0xDD,0xCC,0xBB,0xAA.
REQ-035 Two words 0x44332211, 0x88776655 queued, ready_i = 1 -> 8 consecutive valid beats 0x11..0x88, second pop coincides with 0x44 transfer, no bubble.
REQ-036 ready_i low for 3 cycles at beat 0xBB -> data_o = 0xBB and valid_o = 1 held stable all 3 cycles; cnt unchanged; no pop.
REQ-037 flush_i pulsed at beat 0xBB with FIFO non-empty -> valid_o = 0 next cycle, no pop in flush cycle, next word popped the following cycle, its first beat emitted with cnt = 0.
REQ-038 rst_ni asserted at beat 0xCC -> all outputs 0 immediately; after release with FIFO empty, valid_o and fifo_pop_o stay 0.
